// File: rtl/ahbl_arbiter_2m.sv
// Two-master AHB-Lite arbiter: round-robin address-phase grant with burst and lock
// retention, plus a registered data-phase owner that steers write data and responses.
module ahbl_arbiter_2m #(
  parameter int W_ADDR         = 32,
  parameter int W_DATA         = 32,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [W_ADDR-1:0] m0_haddr,
  input  logic [1:0]        m0_htrans,
  input  logic              m0_hwrite,
  input  logic [2:0]        m0_hsize,
  input  logic [2:0]        m0_hburst,
  input  logic [3:0]        m0_hprot,
  input  logic              m0_hmastlock,
  input  logic [W_DATA-1:0] m0_hwdata,
  output logic              m0_hready,
  output logic              m0_hresp,
  output logic [W_DATA-1:0] m0_hrdata,

  input  logic [W_ADDR-1:0] m1_haddr,
  input  logic [1:0]        m1_htrans,
  input  logic              m1_hwrite,
  input  logic [2:0]        m1_hsize,
  input  logic [2:0]        m1_hburst,
  input  logic [3:0]        m1_hprot,
  input  logic              m1_hmastlock,
  input  logic [W_DATA-1:0] m1_hwdata,
  output logic              m1_hready,
  output logic              m1_hresp,
  output logic [W_DATA-1:0] m1_hrdata,

  output logic [W_ADDR-1:0] dst_haddr,
  output logic [1:0]        dst_htrans,
  output logic              dst_hwrite,
  output logic [2:0]        dst_hsize,
  output logic [2:0]        dst_hburst,
  output logic [3:0]        dst_hprot,
  output logic              dst_hmastlock,
  output logic [W_DATA-1:0] dst_hwdata,
  output logic              dst_hready,
  input  logic              dst_hready_resp,
  input  logic              dst_hresp,
  input  logic [W_DATA-1:0] dst_hrdata
);

  localparam logic       DEF_M         = (DEFAULT_MASTER != 0);
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  logic addr_owner_q, addr_owner_d;
  logic data_owner_q, data_owner_d;
  logic data_valid_q, data_valid_d;
  logic rr_last_q,    rr_last_d;

  logic owner_req;
  logic other_req;
  logic hold_grant;

  assign dst_haddr     = addr_owner_q ? m1_haddr     : m0_haddr;
  assign dst_htrans    = addr_owner_q ? m1_htrans    : m0_htrans;
  assign dst_hwrite    = addr_owner_q ? m1_hwrite    : m0_hwrite;
  assign dst_hsize     = addr_owner_q ? m1_hsize     : m0_hsize;
  assign dst_hburst    = addr_owner_q ? m1_hburst    : m0_hburst;
  assign dst_hprot     = addr_owner_q ? m1_hprot     : m0_hprot;
  assign dst_hmastlock = addr_owner_q ? m1_hmastlock : m0_hmastlock;
  assign dst_hwdata    = data_owner_q ? m1_hwdata    : m0_hwdata;
  assign dst_hready    = dst_hready_resp;

  assign owner_req = dst_htrans[1];
  assign other_req = addr_owner_q ? m0_htrans[1] : m1_htrans[1];

  // A NONSEQ that opens a multi-beat burst is already accepted by the slave at
  // this boundary, so yielding now would split the burst from its SEQ beats.
  assign hold_grant = (dst_htrans == HTRANS_SEQ) || dst_hmastlock ||
                      ((dst_htrans == HTRANS_NONSEQ) && (dst_hburst != HBURST_SINGLE));

  always_comb begin
    addr_owner_d = addr_owner_q;
    data_owner_d = data_owner_q;
    data_valid_d = data_valid_q;
    rr_last_d    = rr_last_q;
    if (dst_hready_resp) begin
      data_owner_d = addr_owner_q;
      data_valid_d = owner_req;
      if (owner_req) begin
        rr_last_d = addr_owner_q;
      end
      if (!hold_grant && other_req) begin
        addr_owner_d = ~addr_owner_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_owner_q <= DEF_M;
      data_owner_q <= DEF_M;
      data_valid_q <= 1'b0;
      rr_last_q    <= DEF_M;
    end else begin
      addr_owner_q <= addr_owner_d;
      data_owner_q <= data_owner_d;
      data_valid_q <= data_valid_d;
      rr_last_q    <= rr_last_d;
    end
  end

  // Waiting masters are stalled; only the address owner and data-phase owner see the slave.
  assign m0_hready = dst_hready_resp & (~addr_owner_q | (data_valid_q & ~data_owner_q));
  assign m1_hready = dst_hready_resp & ( addr_owner_q | (data_valid_q &  data_owner_q));
  assign m0_hresp  = dst_hresp & data_valid_q & ~data_owner_q;
  assign m1_hresp  = dst_hresp & data_valid_q &  data_owner_q;
  assign m0_hrdata = dst_hrdata;
  assign m1_hrdata = dst_hrdata;

endmodule

// File: tb/tb_ahbl_arbiter_2m.sv
// Directed bench for ahbl_arbiter_2m: grant handover, contention, bursts, lock, error, reset.
module tb_ahbl_arbiter_2m;

  logic        clk;
  logic        rst;
  logic [31:0] m0_haddr, m1_haddr;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize;
  logic [2:0]  m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic        m0_hmastlock, m1_hmastlock;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic        m0_hready, m1_hready;
  logic        m0_hresp, m1_hresp;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic [31:0] dst_haddr;
  logic [1:0]  dst_htrans;
  logic        dst_hwrite;
  logic [2:0]  dst_hsize;
  logic [2:0]  dst_hburst;
  logic [3:0]  dst_hprot;
  logic        dst_hmastlock;
  logic [31:0] dst_hwdata;
  logic        dst_hready;
  logic        dst_hready_resp;
  logic        dst_hresp;
  logic [31:0] dst_hrdata;

  int n_chk;
  int n_fail;

  ahbl_arbiter_2m #(.W_ADDR(32), .W_DATA(32), .DEFAULT_MASTER(0)) dut (
    .clk(clk), .rst(rst),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
    .m0_hburst(m0_hburst), .m0_hprot(m0_hprot), .m0_hmastlock(m0_hmastlock),
    .m0_hwdata(m0_hwdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp), .m0_hrdata(m0_hrdata),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
    .m1_hburst(m1_hburst), .m1_hprot(m1_hprot), .m1_hmastlock(m1_hmastlock),
    .m1_hwdata(m1_hwdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp), .m1_hrdata(m1_hrdata),
    .dst_haddr(dst_haddr), .dst_htrans(dst_htrans), .dst_hwrite(dst_hwrite),
    .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
    .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata), .dst_hready(dst_hready),
    .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp), .dst_hrdata(dst_hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_addr2 [4];
  logic [31:0] exp_wd2   [4];
  logic [31:0] exp_addr3 [4];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    exp_addr2 = '{32'h4900_0000, 32'h4800_0000, 32'h4900_0000, 32'h4800_0000};
    exp_wd2   = '{32'h0000_0000, 32'h0000_00B1, 32'h0000_00A0, 32'h0000_00B1};
    exp_addr3 = '{32'h4800_0100, 32'h4800_0104, 32'h4800_0108, 32'h4800_010C};

    rst = 1'b1;
    m0_haddr = 32'h4000_0000; m0_htrans = 2'b00; m0_hwrite = 1'b0; m0_hsize = 3'b010;
    m0_hburst = 3'b000; m0_hprot = 4'b0011; m0_hmastlock = 1'b0; m0_hwdata = 32'h0;
    m1_haddr = 32'h0; m1_htrans = 2'b00; m1_hwrite = 1'b0; m1_hsize = 3'b010;
    m1_hburst = 3'b000; m1_hprot = 4'b0011; m1_hmastlock = 1'b0; m1_hwdata = 32'h0;
    dst_hready_resp = 1'b1; dst_hresp = 1'b1; dst_hrdata = 32'h0;

    // reset state: owner is m0, no data phase so hresp is blocked
    repeat (2) tick();
    @(negedge clk);
    chk("rst_m0_hready", 32'(m0_hready), 32'd1);
    chk("rst_m1_hready", 32'(m1_hready), 32'd0);
    chk("rst_m0_hresp",  32'(m0_hresp),  32'd0);
    chk("rst_m1_hresp",  32'(m1_hresp),  32'd0);
    tick();
    rst = 1'b0; dst_hresp = 1'b0;

    // m1 single read: one stall cycle, then granted, then data returned
    m1_htrans = 2'b10; m1_haddr = 32'h4200_0000; m1_hwrite = 1'b0;
    @(negedge clk);
    chk("t1_wait_m1_hready", 32'(m1_hready), 32'd0);
    chk("t1_wait_dst_haddr", dst_haddr, 32'h4000_0000);
    tick();
    @(negedge clk);
    chk("t1_addr_dst_haddr",  dst_haddr, 32'h4200_0000);
    chk("t1_addr_dst_htrans", 32'(dst_htrans), 32'd2);
    chk("t1_addr_dst_hwrite", 32'(dst_hwrite), 32'd0);
    chk("t1_addr_m1_hready",  32'(m1_hready), 32'd1);
    tick();
    m1_htrans = 2'b00; dst_hrdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("t1_data_m1_hrdata", m1_hrdata, 32'hCAFE_F00D);
    chk("t1_data_m1_hready", 32'(m1_hready), 32'd1);
    chk("t1_data_m0_hready", 32'(m0_hready), 32'd0);
    tick();

    // contention of single writes: one transfer each, write data follows data owner
    m0_htrans = 2'b10; m0_haddr = 32'h4800_0000; m0_hwrite = 1'b1; m0_hwdata = 32'h0000_00A0;
    m1_htrans = 2'b10; m1_haddr = 32'h4900_0000; m1_hwrite = 1'b1; m1_hwdata = 32'h0000_00B1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t2_dst_haddr_%0d", i), dst_haddr, exp_addr2[i]);
      if (i > 0) chk($sformatf("t2_dst_hwdata_%0d", i), dst_hwdata, exp_wd2[i]);
      tick();
    end
    m0_htrans = 2'b00; m1_htrans = 2'b00;
    tick();

    // m0 INCR4 burst while m1 requests: four m0 beats, then m1
    m0_htrans = 2'b10; m0_haddr = 32'h4800_0100; m0_hburst = 3'b011; m0_hwrite = 1'b0;
    @(negedge clk);
    chk("t3_wait_m0_hready", 32'(m0_hready), 32'd0);
    tick();
    m1_htrans = 2'b10; m1_haddr = 32'h4900_0100; m1_hwrite = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m0_htrans = (k == 0) ? 2'b10 : 2'b11;
      m0_haddr  = exp_addr3[k];
      @(negedge clk);
      chk($sformatf("t3_beat_dst_haddr_%0d", k), dst_haddr, exp_addr3[k]);
      chk($sformatf("t3_beat_m1_hready_%0d", k), 32'(m1_hready), 32'd0);
      tick();
    end
    m0_htrans = 2'b00; m0_hburst = 3'b000;
    @(negedge clk);
    chk("t3_idle_dst_htrans", 32'(dst_htrans), 32'd0);
    tick();
    @(negedge clk);
    chk("t3_m1_dst_haddr",  dst_haddr, 32'h4900_0100);
    chk("t3_m1_hready",     32'(m1_hready), 32'd1);
    tick();
    m1_htrans = 2'b00;
    tick();

    // m1 locked sequence holds off m0 until hmastlock drops
    m0_htrans = 2'b10; m0_haddr = 32'h4800_0200;
    m1_htrans = 2'b10; m1_hmastlock = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m1_haddr = 32'h4900_0200 + 32'(4 * k);
      @(negedge clk);
      chk($sformatf("t4_lock_dst_haddr_%0d", k), dst_haddr, 32'h4900_0200 + 32'(4 * k));
      chk($sformatf("t4_lock_m0_hready_%0d", k), 32'(m0_hready), 32'd0);
      if (k == 0) chk("t4_lock_dst_hmastlock", 32'(dst_hmastlock), 32'd1);
      tick();
    end
    m1_htrans = 2'b00; m1_hmastlock = 1'b0;
    @(negedge clk);
    chk("t4_unlock_m0_hready", 32'(m0_hready), 32'd0);
    tick();
    m1_htrans = 2'b00;
    @(negedge clk);
    chk("t4_m0_dst_haddr", dst_haddr, 32'h4800_0200);
    chk("t4_m0_hready",    32'(m0_hready), 32'd1);
    tick();

    // two wait states then ERROR on m0's data phase; m1 waits with the grant frozen
    m0_haddr = 32'h4800_0300;
    m1_htrans = 2'b10; m1_haddr = 32'h4900_0300;
    dst_hready_resp = 1'b0;
    @(negedge clk);
    chk("t5_w1_dst_haddr",  dst_haddr, 32'h4800_0300);
    chk("t5_w1_m0_hready",  32'(m0_hready), 32'd0);
    chk("t5_w1_m1_hready",  32'(m1_hready), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_w2_dst_haddr",  dst_haddr, 32'h4800_0300);
    chk("t5_w2_m0_hresp",   32'(m0_hresp), 32'd0);
    tick();
    dst_hresp = 1'b1; m0_htrans = 2'b00;
    @(negedge clk);
    chk("t5_e1_m0_hresp",    32'(m0_hresp), 32'd1);
    chk("t5_e1_m1_hresp",    32'(m1_hresp), 32'd0);
    chk("t5_e1_dst_htrans",  32'(dst_htrans), 32'd0);
    tick();
    dst_hready_resp = 1'b1;
    @(negedge clk);
    chk("t5_e2_m0_hresp",   32'(m0_hresp), 32'd1);
    chk("t5_e2_m1_hresp",   32'(m1_hresp), 32'd0);
    chk("t5_e2_m0_hready",  32'(m0_hready), 32'd1);
    chk("t5_e2_m1_hready",  32'(m1_hready), 32'd0);
    tick();
    dst_hresp = 1'b0;
    @(negedge clk);
    chk("t5_m1_dst_haddr", dst_haddr, 32'h4900_0300);
    chk("t5_m1_hready",    32'(m1_hready), 32'd1);
    chk("t5_m1_m0_hresp",  32'(m0_hresp), 32'd0);
    tick();

    // reset during m1's stalled data phase abandons it
    m1_htrans = 2'b00; dst_hready_resp = 1'b0; dst_hresp = 1'b1;
    @(negedge clk);
    chk("t6_pre_m1_hresp", 32'(m1_hresp), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_m1_hresp", 32'(m1_hresp), 32'd0);
    tick();
    rst = 1'b0; dst_hready_resp = 1'b1;
    @(negedge clk);
    chk("t6_post_m1_hresp",  32'(m1_hresp),  32'd0);
    chk("t6_post_m0_hresp",  32'(m0_hresp),  32'd0);
    chk("t6_post_m0_hready", 32'(m0_hready), 32'd1);
    chk("t6_post_m1_hready", 32'(m1_hready), 32'd0);
    tick();
    @(negedge clk);
    chk("t6_next_m1_hresp",  32'(m1_hresp),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
